// File: rtl/mult_hilo_ctrl.sv
// HI/LO write-back controller for an external combinational Booth multiplier.
// Operands are registered, then held for LAT clocks before the product is captured.
module mult_hilo_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mx,
    output logic [WIDTH-1:0]   my,
    input  logic [2*WIDTH-1:0] mp,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               ld_op;
    logic               cap;
    logic               abort;
    logic               wr_hi;
    logic               wr_lo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: flush and the final count both return to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (flush || (cnt == CNT_W'(1))) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Decoded controls; flush outranks capture on the same edge
    always_comb begin
        ld_op = 1'b0;
        cap   = 1'b0;
        abort = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE: begin
                ld_op = start;
                wr_hi = hi_we;
                wr_lo = lo_we;
            end
            CALC: begin
                busy  = 1'b1;
                abort = flush;
                cap   = !flush && (cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    // Operand registers and settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx  <= '0;
            my  <= '0;
            cnt <= '0;
        end else if (ld_op) begin
            mx  <= a;
            my  <= b;
            cnt <= CNT_W'(LAT);
        end else if (abort || cap) begin
            cnt <= '0;
        end else if (state == CALC) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // HI/LO: product capture in CALC, MTHI/MTLO writes in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= cap;
            if (cap) begin
                hi <= mp[2*WIDTH-1:WIDTH];
                lo <= mp[WIDTH-1:0];
            end else begin
                if (wr_hi) begin
                    hi <= wdata;
                end
                if (wr_lo) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl: three instances (LAT=2, 1, 15) with a
// behavioural signed multiplier on each mp input.
module tb_mult_hilo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;

    logic        start_v [3];
    logic [31:0] mx_v    [3];
    logic [31:0] my_v    [3];
    logic [63:0] mp_v    [3];
    logic [31:0] hi_v    [3];
    logic [31:0] lo_v    [3];
    logic        busy_v  [3];
    logic        done_v  [3];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [6];

    mult_hilo_ctrl #(.WIDTH(32), .LAT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .flush(flush), .a(a), .b(b),
        .mx(mx_v[0]), .my(my_v[0]), .mp(mp_v[0]), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi_v[0]), .lo(lo_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    mult_hilo_ctrl #(.WIDTH(32), .LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .flush(flush), .a(a), .b(b),
        .mx(mx_v[1]), .my(my_v[1]), .mp(mp_v[1]), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi_v[1]), .lo(lo_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    mult_hilo_ctrl #(.WIDTH(32), .LAT(15)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .flush(flush), .a(a), .b(b),
        .mx(mx_v[2]), .my(my_v[2]), .mp(mp_v[2]), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi_v[2]), .lo(lo_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_mul
        assign mp_v[g] = 64'($signed(mx_v[g])) * 64'($signed(my_v[g]));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // One multiply on instance idx; measures busy length, done edge and count
    task automatic run_mul(input int idx, input int lat, input logic [31:0] ta,
                           input logic [31:0] tb, input logic [31:0] eh,
                           input logic [31:0] el, input string nm);
        int done_edge;
        int dones;
        int busy_cycles;
        @(negedge clk);
        a = ta;
        b = tb;
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        check({nm, " busy_e0"}, 64'(busy_v[idx]), 64'd1);
        check({nm, " mx"}, 64'(mx_v[idx]), 64'(ta));
        check({nm, " my"}, 64'(my_v[idx]), 64'(tb));
        done_edge   = -1;
        dones       = 0;
        busy_cycles = 1;
        for (int k = 1; k <= lat + 3; k++) begin
            @(posedge clk); #1;
            if (done_v[idx]) begin
                dones++;
                if (done_edge < 0) done_edge = k;
            end
            if (busy_v[idx]) busy_cycles++;
        end
        check({nm, " busy_cycles"}, 64'(busy_cycles), 64'(lat));
        check({nm, " done_edge"}, 64'(done_edge), 64'(lat));
        check({nm, " done_count"}, 64'(dones), 64'd1);
        check({nm, " hi"}, 64'(hi_v[idx]), 64'(eh));
        check({nm, " lo"}, 64'(lo_v[idx]), 64'(el));
    endtask

    initial begin
        vecs[0] = '{32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[5] = '{32'd5,        32'd6,        32'h0000_0000, 32'd30};

        rst_n = 1'b0;
        flush = 1'b0;
        a = '0;
        b = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst hi", 64'(hi_v[0]), 64'd0);
        check("rst lo", 64'(lo_v[0]), 64'd0);
        check("rst mx", 64'(mx_v[0]), 64'd0);
        check("rst busy", 64'(busy_v[0]), 64'd0);
        check("rst done", 64'(done_v[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed product vectors, LAT=2
        for (int i = 0; i < 6; i++) begin
            run_mul(0, 2, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
        end

        // Second start and MTHI/MTLO while busy are ignored
        @(negedge clk);
        a = 32'd3;
        b = 32'd4;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        a = 32'd9;
        b = 32'd9;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_DEAD;
        @(posedge clk); #1;
        check("ign mx", 64'(mx_v[0]), 64'd3);
        check("ign my", 64'(my_v[0]), 64'd4);
        check("ign done_e1", 64'(done_v[0]), 64'd0);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("ign hi", 64'(hi_v[0]), 64'd0);
        check("ign lo", 64'(lo_v[0]), 64'd12);
        check("ign done", 64'(done_v[0]), 64'd1);
        check("ign busy", 64'(busy_v[0]), 64'd0);
        @(posedge clk); #1;
        check("ign done_off", 64'(done_v[0]), 64'd0);
        check("ign no_restart", 64'(busy_v[0]), 64'd0);

        // MTHI then MTLO in IDLE
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h9ABC_DEF0;
        @(negedge clk);
        lo_we = 1'b0;
        check("mt hi", 64'(hi_v[0]), 64'h1234_5678);
        check("mt lo", 64'(lo_v[0]), 64'h9ABC_DEF0);

        // Flush one cycle after start
        a = 32'd2;
        b = 32'd2;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl1 busy", 64'(busy_v[0]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("fl1 done%0d", k), 64'(done_v[0]), 64'd0);
            @(posedge clk); #1;
        end
        check("fl1 hi", 64'(hi_v[0]), 64'h1234_5678);
        check("fl1 lo", 64'(lo_v[0]), 64'h9ABC_DEF0);

        // Flush on the capture edge wins over capture
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl2 busy", 64'(busy_v[0]), 64'd0);
        check("fl2 done", 64'(done_v[0]), 64'd0);
        check("fl2 hi", 64'(hi_v[0]), 64'h1234_5678);
        check("fl2 lo", 64'(lo_v[0]), 64'h9ABC_DEF0);
        @(posedge clk); #1;
        check("fl2 done_late", 64'(done_v[0]), 64'd0);

        // Start with MTHI+MTLO and flush on the same IDLE edge
        @(negedge clk);
        a = 32'd2;
        b = 32'd3;
        start_v[0] = 1'b1;
        flush = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("sw busy", 64'(busy_v[0]), 64'd1);
        check("sw hi_wr", 64'(hi_v[0]), 64'hA5A5_A5A5);
        check("sw lo_wr", 64'(lo_v[0]), 64'hA5A5_A5A5);
        repeat (2) @(posedge clk);
        #1;
        check("sw hi", 64'(hi_v[0]), 64'd0);
        check("sw lo", 64'(lo_v[0]), 64'd6);
        check("sw done", 64'(done_v[0]), 64'd1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        a = 32'd7;
        b = 32'hFFFF_FFFD;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check("ar busy_pre", 64'(busy_v[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar hi", 64'(hi_v[0]), 64'd0);
        check("ar lo", 64'(lo_v[0]), 64'd0);
        check("ar mx", 64'(mx_v[0]), 64'd0);
        check("ar my", 64'(my_v[0]), 64'd0);
        check("ar busy", 64'(busy_v[0]), 64'd0);
        check("ar done", 64'(done_v[0]), 64'd0);
        @(posedge clk); #1;
        check("ar done_edge", 64'(done_v[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar done_after", 64'(done_v[0]), 64'd0);
        run_mul(0, 2, 32'd5, 32'd6, 32'd0, 32'd30, "ar 5x6");

        // Latency extremes
        run_mul(1, 1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "lat1");
        run_mul(2, 15, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "lat15");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_hilo_ctrl.md
MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; the product is 2*WIDTH.
REQ-002 SHALL have parameter LAT, default 2, multicycle settle time of the combinational Booth multiplier in clocks; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, request for a signed multiply of a by b.
REQ-006 SHALL have port flush, input, 1, cancel of the in-flight multiply.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port mx, output, WIDTH, registered multiplicand driving the Booth multiplier x input.
REQ-010 SHALL have port my, output, WIDTH, registered multiplier driving the Booth multiplier y input.
REQ-011 SHALL have port mp, input, 2*WIDTH, signed product returned by the Booth multiplier.
REQ-012 SHALL have port hi_we, input, 1, MTHI write strobe.
REQ-013 SHALL have port lo_we, input, 1, MTLO write strobe.
REQ-014 SHALL have port wdata, input, WIDTH, MTHI/MTLO data.
REQ-015 SHALL have port hi, output, WIDTH, HI register.
REQ-016 SHALL have port lo, output, WIDTH, LO register.
REQ-017 SHALL have port busy, output, 1, multiply in flight; pipeline stall request.
REQ-018 SHALL have port done, output, 1, one-cycle pulse on HI/LO update by a multiply.

Function
REQ-019 SHALL implement FSM states IDLE and CALC, with a 4-bit down-counter cnt.
REQ-020 SHALL, in IDLE with start=1 at edge E0: load mx<=a, my<=b, cnt<=LAT, state<=CALC.
REQ-021 SHALL assert busy combinationally whenever state=CALC.
REQ-022 SHALL, in CALC with flush=0, decrement cnt each edge.
REQ-023 SHALL, at the edge where cnt=1 (edge E0+LAT): capture hi<=mp[2*WIDTH-1:WIDTH], lo<=mp[WIDTH-1:0], state<=IDLE, done<=1.
REQ-024 SHALL drive done registered, high exactly for the one cycle after the capture edge, otherwise 0.
REQ-025 SHALL keep the write-back latency from start acceptance to HI/LO valid at exactly LAT edges, with done visible in the cycle after.
REQ-026 SHALL hold mx/my stable for the whole of CALC, satisfying the multicycle path.
REQ-027 SHALL ignore start while in CALC; no queuing.
REQ-028 SHALL, in CALC with flush=1: state<=IDLE at the next edge, hi/lo unchanged, no done pulse; flush in IDLE has no effect.
REQ-029 SHALL give flush priority over capture when both fall on the same edge; the result is discarded.
REQ-030 SHALL, in IDLE, apply hi_we to hi<=wdata and lo_we to lo<=wdata; both may fire together.
REQ-031 SHALL ignore hi_we/lo_we while in CALC.
REQ-032 SHALL, in IDLE with start and hi_we/lo_we on the same edge, perform the MTHI/MTLO write and accept the start; the later capture overwrites.
REQ-033 SHALL, when start and flush arrive together in IDLE, accept the start.
REQ-034 SHALL treat operands and product as two's complement signed; mp is passed through unmodified, with no rounding or saturation.
REQ-035 SHALL generate no combinational path from mp to any output.

Reset
REQ-036 SHALL, on rst_n low, immediately force state=IDLE, cnt=0, mx=0, my=0, hi=0, lo=0, done=0 and busy=0.
REQ-037 SHALL, on reset during CALC, abandon the operation with no done pulse; first start after rst_n rises is accepted normally.

Verification
REQ-038 SHALL test: LAT=2, start with a=7, b=-3 (0xFFFFFFFD) -> busy for 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; done single pulse.
REQ-039 SHALL test: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; a=b=0xFFFFFFFF -> hi=0, lo=1.
REQ-040 SHALL test: second start and hi_we during busy -> ignored; hi/lo reflect only the first multiply.
REQ-041 SHALL test: hi_we=1 with wdata=0x12345678, and lo_we=1 with wdata=0x9ABCDEF0, in IDLE -> hi=0x12345678, lo=0x9ABCDEF0; then flush one cycle after start -> hi/lo unchanged, done never asserted.
REQ-042 SHALL test: rst_n pulsed low mid-CALC -> all outputs 0 asynchronously, no done pulse; a new multiply 5*6 completes with lo=30, hi=0.
REQ-043 SHALL test: LAT=1 and LAT=15 -> capture exactly 1 and 15 edges after acceptance respectively.
